fir_stream_ctrl: RTL and testbench
==================================

FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

Interface
REQ-001 Parameter DEPTH, 4, input FIFO depth in samples (power of 2, 2..16).
REQ-002 Parameter TIMEOUT, 64, max cycles waited for FIR completion (used only with FIR_TIMEOUT_EN).
REQ-003 ck  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s_data  input  16  signed sample from upstream.
REQ-006 s_valid  input  1  upstream sample valid.
REQ-007 s_ready  output  1  controller can accept a sample.
REQ-008 m_data  output  16  signed filtered result to downstream.
REQ-009 m_valid  output  1  m_data valid.
REQ-010 m_ready  input  1  downstream accepts m_data.
REQ-011 fir_in  output  16  sample driven to FIR datapath.
REQ-012 fir_input_ready  output  1  one-cycle start pulse to FIR.
REQ-013 fir_out  input  16  FIR result; valid the cycle after fir_output_ready.
REQ-014 fir_output_ready  input  1  FIR completion pulse.
REQ-015 busy  output  1  high when state != IDLE or FIFO non-empty.
REQ-016 sample_count  output  16  results delivered downstream, wraps 0xFFFF->0x0000.
REQ-017 timeout_err  output  1  sticky FIR watchdog error flag.

Function
REQ-018 Input FIFO SHALL store DEPTH samples; s_ready = !full; push when s_valid && s_ready.
REQ-019 Simultaneous push and pop SHALL leave occupancy unchanged; push when full SHALL be impossible (s_ready low); pop when empty SHALL never occur.
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, CAPTURE.
REQ-021 IDLE -> ISSUE when FIFO non-empty and output slot free (m_valid==0, or m_valid && m_ready this cycle).
REQ-022 ISSUE: fir_input_ready=1 for exactly one cycle, FIFO head popped into fir_in register -> WAIT.
REQ-023 fir_in SHALL be registered and stay stable from ISSUE until the next ISSUE.
REQ-024 WAIT: fir_output_ready sampled high -> CAPTURE; otherwise stay.
REQ-025 CAPTURE: m_data <= fir_out, m_valid <= 1 -> IDLE.
REQ-026 m_valid SHALL stay high and m_data stable until m_valid && m_ready; m_valid then clears next edge.
REQ-027 At most one sample SHALL be in flight in the FIR; at most one result held in m_data.
REQ-028 fir_output_ready outside WAIT SHALL be ignored.
REQ-029 sample_count increments by 1 on each m_valid && m_ready.
REQ-030 Minimum issue-to-m_valid latency SHALL be FIR latency + 2 cycles (fir_output_ready edge -> CAPTURE -> m_valid).
REQ-031 Sample order SHALL be preserved end to end; no sample dropped except per REQ-036.

Reset
REQ-032 rst asserted: state IDLE, FIFO empty (s_ready=1), m_valid=0, m_data=0, fir_in=0, fir_input_ready=0, busy=0, sample_count=0, timeout_err=0.
REQ-033 rst mid-operation SHALL abort any in-flight sample and discard FIFO contents; FIR datapath SHALL share the same rst.
REQ-034 First issue after rst deassertion no earlier than the second rising edge.

Configuration
REQ-035 Macro FIR_TIMEOUT_EN SHALL select the FIR watchdog.
REQ-036 Defined: cycle counter cleared on entering WAIT; on TIMEOUT cycles in WAIT without fir_output_ready, timeout_err set (sticky until rst), sample dropped, WAIT -> IDLE, m_valid unchanged.
REQ-037 Undefined: WAIT held indefinitely; timeout_err port present, tied 0; no counter logic.

Verification
REQ-038 Bench SHALL use FIR stub: fir_output_ready pulses 18 cycles after fir_input_ready, fir_out = fir_in ^ 16'h00FF the following cycle.
REQ-039 Single sample 16'h1234, m_ready=1 -> one fir_input_ready pulse, m_data=16'h12CB, m_valid for 1 cycle, sample_count=1.
REQ-040 Burst 6 samples 1..6 back-to-back, m_ready=1 -> s_ready low after 4 stored while first in flight; outputs 16'h00FE,00FD,00FC,00FB,00FA,00F9 in order.
REQ-041 m_ready=0 for 100 cycles after first result -> m_data held, no second fir_input_ready until m_ready=1.
REQ-042 rst asserted during WAIT with 3 samples queued -> all outputs at reset values immediately, no m_valid after release.
REQ-043 FIR_TIMEOUT_EN defined, stub never pulses fir_output_ready -> timeout_err=1 exactly 64 cycles after entering WAIT, next sample issued; undefined -> controller remains in WAIT, busy=1.

Source files
------------

// File: rtl/fir_stream_ctrl_if.sv
// fir_stream_ctrl_if
//   Groups the stream and FIR-datapath handshakes of fir_stream_ctrl.
//   All data buses carry 16-bit two's-complement samples.
//
//   s_data / s_valid / s_ready             upstream sample stream
//   m_data / m_valid / m_ready             downstream result stream
//   fir_in / fir_input_ready               sample + start pulse to the FIR
//   fir_out / fir_output_ready             FIR completion pulse + result
//
//   master : controller side
//   slave  : environment side (upstream, downstream and FIR datapath)
interface fir_stream_ctrl_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] fir_in;
  logic        fir_input_ready;
  logic [15:0] fir_out;
  logic        fir_output_ready;

  modport master (
    input  s_data, s_valid, m_ready, fir_out, fir_output_ready,
    output s_ready, m_data, m_valid, fir_in, fir_input_ready
  );

  modport slave (
    output s_data, s_valid, m_ready, fir_out, fir_output_ready,
    input  s_ready, m_data, m_valid, fir_in, fir_input_ready
  );
endinterface

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl
//   Streaming controller around a multi-cycle FIR datapath. Incoming samples
//   are buffered in a DEPTH-entry FIFO; one sample at a time is launched into
//   the FIR, and its result is held on the downstream port until accepted.
//
//   Parameters
//     DEPTH    input FIFO depth in samples (power of 2, 2..16)
//     TIMEOUT  FIR watchdog limit in cycles (only with FIR_TIMEOUT_EN)
//
//   Ports
//     ck            clock, rising edge
//     rst           asynchronous active-high reset
//     bus           fir_stream_ctrl_if.master (stream + FIR handshakes)
//     busy          state != IDLE or FIFO non-empty
//     sample_count  results delivered downstream (wraps)
//     timeout_err   sticky FIR watchdog error
//
//   Build option
//     FIR_TIMEOUT_EN  when defined, a sample stuck in WAIT for TIMEOUT cycles
//                     is dropped and timeout_err is set; otherwise WAIT is
//                     held indefinitely and timeout_err is tied low.
module fir_stream_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    ck,
  input  logic                    rst,
  fir_stream_ctrl_if.master       bus,
  output logic                    busy,
  output logic [15:0]             sample_count,
  output logic                    timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1)
  begin : g_param_check
    $error("fir_stream_ctrl: DEPTH must be a power of 2 in 2..16, TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE
  } state_t;

  state_t        r_state;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_fir_in;
  logic          r_fir_input_ready;
  logic [15:0]   r_m_data;
  logic          r_m_valid;
  logic [15:0]   r_sample_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_issue;
  logic w_m_hs;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.s_valid && !w_full;
  assign w_m_hs  = r_m_valid && bus.m_ready;
  // The output slot counts as free when the held result leaves this very cycle.
  assign w_issue = (r_state == IDLE) && !w_empty && (!r_m_valid || bus.m_ready);

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge ck) begin
    if (w_push) r_mem[r_wptr] <= bus.s_data;
  end

  // Head is popped on the IDLE->ISSUE edge so fir_in is already valid while
  // the start pulse is high.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_wptr <= r_wptr + 1'b1;
      if (w_issue) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
`ifdef FIR_TIMEOUT_EN
  logic [TW-1:0] r_tcnt;
  logic          r_timeout_err;
`endif

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state           <= IDLE;
      r_fir_in          <= '0;
      r_fir_input_ready <= 1'b0;
      r_m_data          <= '0;
      r_m_valid         <= 1'b0;
`ifdef FIR_TIMEOUT_EN
      r_tcnt            <= '0;
      r_timeout_err     <= 1'b0;
`endif
    end else begin
      r_fir_input_ready <= 1'b0;
      if (w_m_hs) r_m_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_fir_in          <= r_mem[r_rptr];
            r_fir_input_ready <= 1'b1;
            r_state           <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
`ifdef FIR_TIMEOUT_EN
          r_tcnt  <= '0;
`endif
        end
        WAIT: begin
          if (bus.fir_output_ready) begin
            r_state <= CAPTURE;
          end
`ifdef FIR_TIMEOUT_EN
          else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            // Drop the sample; any held result on m_data is left untouched.
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end
        CAPTURE: begin
          // fir_out is valid the cycle after fir_output_ready.
          r_m_data  <= bus.fir_out;
          r_m_valid <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst)         r_sample_count <= '0;
    else if (w_m_hs) r_sample_count <= r_sample_count + 1'b1;
  end

  // ---------------------------------------------------------------- outputs
  assign bus.s_ready         = !w_full;
  assign bus.m_data          = r_m_data;
  assign bus.m_valid         = r_m_valid;
  assign bus.fir_in          = r_fir_in;
  assign bus.fir_input_ready = r_fir_input_ready;
  assign busy                = (r_state != IDLE) || !w_empty;
  assign sample_count        = r_sample_count;
`ifdef FIR_TIMEOUT_EN
  assign timeout_err         = r_timeout_err;
`else
  assign timeout_err         = 1'b0;
`endif

endmodule

// File: tb/tb_fir_stream_ctrl.sv
module tb_fir_stream_ctrl;

  logic        ck;
  logic        rst;
  logic        busy;
  logic [15:0] sample_count;
  logic        timeout_err;

  fir_stream_ctrl_if bus();

  fir_stream_ctrl #(.DEPTH(4), .TIMEOUT(64)) dut (
    .ck           (ck),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .sample_count (sample_count),
    .timeout_err  (timeout_err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ FIR stub
  // Pulses fir_output_ready 18 cycles after fir_input_ready, then presents
  // fir_in ^ 16'h00FF on fir_out the following cycle.
  bit          stub_off = 1'b0;
  int          st_cnt   = 0;
  logic [15:0] st_data  = '0;

  initial begin
    bus.fir_output_ready = 1'b0;
    bus.fir_out          = '0;
    forever begin
      @(posedge ck); #1;
      if (rst) begin
        st_cnt               = 0;
        bus.fir_output_ready = 1'b0;
        bus.fir_out          = '0;
      end else begin
        if (bus.fir_output_ready) begin
          bus.fir_output_ready = 1'b0;
          bus.fir_out          = st_data ^ 16'h00FF;
        end
        if (st_cnt != 0) begin
          st_cnt--;
          if (st_cnt == 0) bus.fir_output_ready = 1'b1;
        end
        if (bus.fir_input_ready && !stub_off) begin
          st_data = bus.fir_in;
          st_cnt  = 18;
        end
      end
    end
  end

  // ------------------------------------------------------------ monitor
  int          cyc = 0;
  int          issue_cnt = 0;
  int          issue_cyc = 0;
  int          mv_rises = 0;
  int          mv_cyc = 0;
  int          hs_cnt = 0;
  int          te_cyc = 0;
  logic        prev_mv = 1'b0;
  logic        prev_te = 1'b0;
  logic [15:0] out_q[$];

  always @(negedge ck) begin
    cyc++;
    if (bus.fir_input_ready) begin
      issue_cnt++;
      issue_cyc = cyc;
    end
    if (bus.m_valid && !prev_mv) begin
      mv_rises++;
      mv_cyc = cyc;
    end
    if (bus.m_valid && bus.m_ready) begin
      out_q.push_back(bus.m_data);
      hs_cnt++;
    end
    if (timeout_err && !prev_te) te_cyc = cyc;
    prev_mv = bus.m_valid;
    prev_te = timeout_err;
  end

  // ------------------------------------------------------------ helpers
  task automatic push(input logic [15:0] d);
    int unsigned g;
    g = 0;
    @(negedge ck);
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && g < 500) begin
      @(negedge ck);
      g++;
    end
    check("push_s_ready", 32'(bus.s_ready), 32'd1);
    @(posedge ck); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_mv(input string name, input int unsigned maxc);
    int unsigned g;
    g = 0;
    @(negedge ck);
    while (!bus.m_valid && g < maxc) begin
      @(negedge ck);
      g++;
    end
    check(name, 32'(bus.m_valid), 32'd1);
    #1;
  endtask

  task automatic wait_hs(input string name, input int target, input int unsigned maxc);
    int unsigned g;
    g = 0;
    while (hs_cnt < target && g < maxc) begin
      @(negedge ck);
      g++;
    end
    #1;
    check(name, 32'(hs_cnt), 32'(target));
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] burst_exp[6];

  initial begin
    int n;
    int base;
    int ib;
    int mvr;
    int viol;
    int accepted;
    int acc_at_low;
    int guard;
    int ic;
    bit saw_low;

    tbl[0] = '{din: 16'h0000, exp: 16'h00FF};
    tbl[1] = '{din: 16'hFFFF, exp: 16'hFF00};
    tbl[2] = '{din: 16'h8000, exp: 16'h80FF};
    tbl[3] = '{din: 16'h7FFF, exp: 16'h7F00};
    tbl[4] = '{din: 16'h00FF, exp: 16'h0000};
    tbl[5] = '{din: 16'hA5A5, exp: 16'hA55A};
    burst_exp[0] = 16'h00FE; burst_exp[1] = 16'h00FD; burst_exp[2] = 16'h00FC;
    burst_exp[3] = 16'h00FB; burst_exp[4] = 16'h00FA; burst_exp[5] = 16'h00F9;

    // ---------------- reset state (s_valid held high during reset)
    rst         = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h1234;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge ck);
    @(negedge ck);
    check("rst_s_ready",         32'(bus.s_ready), 32'd1);
    check("rst_m_valid",         32'(bus.m_valid), 32'd0);
    check("rst_m_data",          32'(bus.m_data), 32'd0);
    check("rst_fir_in",          32'(bus.fir_in), 32'd0);
    check("rst_fir_input_ready", 32'(bus.fir_input_ready), 32'd0);
    check("rst_busy",            32'(busy), 32'd0);
    check("rst_sample_count",    32'(sample_count), 32'd0);
    check("rst_timeout_err",     32'(timeout_err), 32'd0);

    // ---------------- single sample 0x1234, first issue on 2nd edge
    @(posedge ck); #1;
    rst = 1'b0;
    @(posedge ck); #1;        // edge 1: sample pushed
    bus.s_valid = 1'b0;
    n = 1;
    @(negedge ck);
    while (!bus.fir_input_ready && n < 50) begin
      @(negedge ck);
      n++;
    end
    check("first_issue_edge", 32'(n), 32'd2);
    check("first_fir_in", 32'(bus.fir_in), 32'h1234);
    wait_mv("single_mvalid", 100);
    check("single_m_data", 32'(bus.m_data), 32'h12CB);
    check("single_latency", 32'(mv_cyc - issue_cyc), 32'd20);
    @(negedge ck);
    check("single_mvalid_1cyc", 32'(bus.m_valid), 32'd0);
    check("single_count", 32'(sample_count), 32'd1);
    check("single_issues", 32'(issue_cnt), 32'd1);

    // ---------------- table of single transactions
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].din);
      wait_mv("tbl_mvalid", 100);
      check("tbl_m_data", 32'(bus.m_data), 32'(tbl[i].exp));
      check("tbl_latency", 32'(mv_cyc - issue_cyc), 32'd20);
      @(negedge ck);
      check("tbl_mvalid_drop", 32'(bus.m_valid), 32'd0);
      check("tbl_count", 32'(sample_count), 32'(i + 2));
    end
    check("tbl_issues", 32'(issue_cnt), 32'd7);

    // ---------------- back-to-back burst of 1..6
    base       = hs_cnt;
    accepted   = 0;
    acc_at_low = 0;
    saw_low    = 1'b0;
    guard      = 0;
    @(negedge ck);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'd1;
    while (accepted < 6 && guard < 1000) begin
      if (bus.s_ready) begin
        @(posedge ck); #1;
        accepted++;
        bus.s_data = 16'(accepted + 1);
      end else if (!saw_low) begin
        saw_low    = 1'b1;
        acc_at_low = accepted;
      end
      @(negedge ck);
      guard++;
    end
    bus.s_valid = 1'b0;
    check("burst_accepted", 32'(accepted), 32'd6);
    check("burst_saw_full", 32'(saw_low), 32'd1);
    check("burst_full_at", 32'(acc_at_low), 32'd5);
    wait_hs("burst_results", base + 6, 1000);
    for (int i = 0; i < 6; i++) begin
      if (base + i < out_q.size())
        check("burst_order", 32'(out_q[base + i]), 32'(burst_exp[i]));
      else
        check("burst_missing", 32'(out_q.size()), 32'(base + i + 1));
    end

    // ---------------- downstream back-pressure for 100 cycles
    @(posedge ck); #1;
    bus.m_ready = 1'b0;
    base = hs_cnt;
    push(16'h0010);
    push(16'h0020);
    wait_mv("bp_mvalid", 100);
    check("bp_m_data", 32'(bus.m_data), 32'h00EF);
    ib   = issue_cnt;
    viol = 0;
    repeat (100) begin
      @(negedge ck);
      if (!bus.m_valid || bus.m_data !== 16'h00EF) viol++;
    end
    check("bp_hold_violations", 32'(viol), 32'd0);
    check("bp_no_second_issue", 32'(issue_cnt), 32'(ib));
    check("bp_busy", 32'(busy), 32'd1);
    @(posedge ck); #1;
    bus.m_ready = 1'b1;
    wait_hs("bp_results", base + 2, 200);
    if (base + 1 < out_q.size()) begin
      check("bp_first", 32'(out_q[base]), 32'h00EF);
      check("bp_second", 32'(out_q[base + 1]), 32'h00DF);
    end else begin
      check("bp_missing", 32'(out_q.size()), 32'(base + 2));
    end

    // ---------------- reset in WAIT with 3 samples queued
    push(16'h0AAA);
    push(16'h0BBB);
    push(16'h0CCC);
    push(16'h0DDD);
    repeat (4) @(negedge ck);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_mvalid", 32'(bus.m_valid), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(sample_count), 32'd0);
    check("mid_rst_fir_in", 32'(bus.fir_in), 32'd0);
    check("mid_rst_m_data", 32'(bus.m_data), 32'd0);
    check("mid_rst_mvalid", 32'(bus.m_valid), 32'd0);
    repeat (2) @(posedge ck);
    #1;
    rst = 1'b0;
    mvr = mv_rises;
    ib  = issue_cnt;
    repeat (60) @(negedge ck);
    check("post_rst_no_mvalid", 32'(mv_rises), 32'(mvr));
    check("post_rst_no_issue", 32'(issue_cnt), 32'(ib));
    check("post_rst_busy", 32'(busy), 32'd0);

    // ---------------- FIR never completes
    stub_off = 1'b1;
    ib  = issue_cnt;
    mvr = mv_rises;
    push(16'h0100);
    push(16'h0200);
`ifdef FIR_TIMEOUT_EN
    guard = 0;
    while (issue_cnt < ib + 1 && guard < 50) begin
      @(negedge ck);
      guard++;
    end
    #1;
    check("to_first_issue", 32'(issue_cnt), 32'(ib + 1));
    ic = issue_cyc;
    guard = 0;
    while (!timeout_err && guard < 300) begin
      @(negedge ck);
      guard++;
    end
    #1;
    check("to_err_set", 32'(timeout_err), 32'd1);
    check("to_err_delay", 32'(te_cyc - ic), 32'd65);
    guard = 0;
    while (issue_cnt < ib + 2 && guard < 20) begin
      @(negedge ck);
      guard++;
    end
    #1;
    check("to_next_issue", 32'(issue_cnt), 32'(ib + 2));
    check("to_next_issue_gap", 32'(issue_cyc - te_cyc), 32'd1);
    check("to_fir_in", 32'(bus.fir_in), 32'h0200);
    check("to_no_mvalid", 32'(mv_rises), 32'(mvr));
    repeat (10) @(negedge ck);
    check("to_err_sticky", 32'(timeout_err), 32'd1);
`else
    ic = 0;
    repeat (200) @(negedge ck);
    check("nto_busy", 32'(busy), 32'd1);
    check("nto_err", 32'(timeout_err), 32'd0);
    check("nto_single_issue", 32'(issue_cnt), 32'(ib + 1));
    check("nto_fir_in", 32'(bus.fir_in), 32'h0100);
    check("nto_no_mvalid", 32'(mv_rises), 32'(mvr));
    check("nto_ic_unused", 32'(ic), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "global timeout");
  end

endmodule
